// File: rtl/morse_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | morse_rx : serial Morse receiver, classifies marks and emits LSB-first code |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module morse_rx #(
  parameter int DASH_TICKS = 3,
  parameter int GAP_TICKS  = 3,
  parameter int CNT_W      = 4
) (
  input  logic       half_clk,
  input  logic       rst,
  input  logic       key_i,
  output logic [3:0] code_o,
  output logic [2:0] len_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MARK  = 2'd1;
  localparam logic [1:0] SPACE = 2'd2;

  localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             key_meta;
  logic             key_s;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       shreg;
  logic [2:0]       len;
  logic             ovf;
  logic             dash;
  logic             emit;

  always_ff @(posedge half_clk or negedge rst) begin
    if (!rst) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      key_meta <= key_i;
      key_s    <= key_meta;
    end
  end

  assign dash = (cnt >= DASH_MIN);
  // cnt already holds the low samples seen so far, so this edge is the last one
  assign emit = (state == SPACE) && !key_s && (cnt >= GAP_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_s) state_next = MARK;
      MARK:    if (!key_s) state_next = SPACE;
      SPACE: begin
        if (key_s)     state_next = MARK;
        else if (emit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge half_clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      len     <= '0;
      ovf     <= 1'b0;
      code_o  <= '0;
      len_o   <= '0;
      err_o   <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_next;
      busy_o  <= (state_next != IDLE);
      valid_o <= emit;
      case (state)
        IDLE: if (key_s) cnt <= CNT_ONE;
        MARK: begin
          if (key_s) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
          end else begin
            // symbols past the fourth are dropped; only the overflow is remembered
            if (!len[2]) begin
              shreg[len[1:0]] <= dash;
              len             <= len + 3'd1;
            end else begin
              ovf <= 1'b1;
            end
            cnt <= CNT_ONE;
          end
        end
        SPACE: begin
          if (key_s) begin
            cnt <= CNT_ONE;
          end else if (emit) begin
            code_o <= shreg;
            len_o  <= len;
            err_o  <= ovf;
            shreg  <= '0;
            len    <= '0;
            ovf    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_rx.sv
`default_nettype none
// tb_morse_rx : scoreboard bench for morse_rx, expected characters queued as keyed.
module tb_morse_rx;

  logic       half_clk;
  logic       rst;
  logic       key_i;
  logic [3:0] code_o;
  logic [2:0] len_o;
  logic       valid_o;
  logic       err_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_e;

  morse_rx #(.DASH_TICKS(3), .GAP_TICKS(3), .CNT_W(4)) dut (
    .half_clk (half_clk),
    .rst      (rst),
    .key_i    (key_i),
    .code_o   (code_o),
    .len_o    (len_o),
    .valid_o  (valid_o),
    .err_o    (err_o),
    .busy_o   (busy_o)
  );

  initial half_clk = 1'b0;
  always #5 half_clk = ~half_clk;

  // scoreboard: every strobe pops one queued {code, len, err}
  always @(negedge half_clk) begin
    if (valid_o) begin
      n_valid++;
      n_checks++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL strobe_width: valid_o high on consecutive cycles, required one-cycle pulse");
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got code=%b len=%0d err=%b, required no strobe",
                 code_o, len_o, err_o);
      end else begin
        exp_e = exp_q.pop_front();
        if ({code_o, len_o, err_o} !== exp_e)
          begin
            n_fail++;
            $display("FAIL char: got code=%b len=%0d err=%b, required code=%b len=%0d err=%b",
                     code_o, len_o, err_o, exp_e[7:4], exp_e[3:1], exp_e[0]);
          end
      end
    end
    prev_valid = valid_o;
  end

  task automatic drive(input logic v, input int n);
    key_i = v;
    repeat (n) @(negedge half_clk);
  endtask

  task automatic expect_char(input logic [3:0] c, input logic [2:0] l, input logic e);
    exp_q.push_back({c, l, e});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge half_clk);
    repeat (4) @(negedge half_clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_i = 1'b0;
    repeat (3) @(negedge half_clk);
    key_i = 1'b1;
    repeat (4) @(negedge half_clk);
    n_checks++;
    if ({code_o, len_o, valid_o, err_o, busy_o} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got code=%b len=%0d valid=%b err=%b busy=%b, required all 0",
               code_o, len_o, valid_o, err_o, busy_o);
    end
    key_i = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge half_clk);
    n_checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b valid=%b, required 0 0", busy_o, valid_o);
    end
  endtask

  task automatic test_letter_a();
    int lat;
    expect_char(4'b0010, 3'd2, 1'b0);
    drive(1, 1); drive(0, 1); drive(1, 3);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_char: got busy=%b, required 1", busy_o);
    end
    key_i = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge half_clk);
      if (valid_o) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL a_latency: got %0d edges, required 5", lat);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_at_emit: got busy=%b, required 0", busy_o);
    end
    wait_drain();
    n_checks++;
    if (code_o !== 4'b0010 || len_o !== 3'd2) begin
      n_fail++;
      $display("FAIL a_hold: got code=%b len=%0d, required code=0010 len=2", code_o, len_o);
    end
  endtask

  task automatic test_dash_threshold();
    expect_char(4'b0000, 3'd1, 1'b0);
    drive(1, 2); drive(0, 3);
    wait_drain();
    expect_char(4'b0001, 3'd1, 1'b0);
    drive(1, 3); drive(0, 3);
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL dash_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_gap_threshold();
    int v0;
    v0 = n_valid;
    expect_char(4'b0000, 3'd2, 1'b0);
    drive(1, 1); drive(0, 2); drive(1, 1); drive(0, 3);
    wait_drain();
    n_checks++;
    if (n_valid - v0 != 1) begin
      n_fail++;
      $display("FAIL gap_short_count: got %0d strobes, required 1", n_valid - v0);
    end
    v0 = n_valid;
    expect_char(4'b0000, 3'd1, 1'b0);
    expect_char(4'b0000, 3'd1, 1'b0);
    drive(1, 1); drive(0, 3); drive(1, 1); drive(0, 3);
    wait_drain();
    n_checks++;
    if (n_valid - v0 != 2) begin
      n_fail++;
      $display("FAIL gap_full_count: got %0d strobes, required 2", n_valid - v0);
    end
  endtask

  task automatic test_overflow();
    expect_char(4'b0000, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1); drive(0, 1);
    end
    drive(1, 1); drive(0, 3);
    wait_drain();
    expect_char(4'b0001, 3'd1, 1'b0);
    drive(1, 3); drive(0, 3);
    wait_drain();
    // dash dot dash dot dash: only the first four symbols survive
    expect_char(4'b0101, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1, (i % 2 == 0) ? 3 : 1); drive(0, 1);
    end
    drive(1, 3); drive(0, 3);
    wait_drain();
    n_checks++;
    if (err_o !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_hold: got err=%b pending=%0d, required err=1 pending=0", err_o, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_char();
    int v0;
    v0 = n_valid;
    drive(1, 3); drive(0, 1); drive(1, 3); drive(0, 1);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({code_o, len_o, valid_o, err_o, busy_o} !== 10'b0) begin
      n_fail++;
      $display("FAIL async_reset: got code=%b len=%0d valid=%b err=%b busy=%b, required all 0",
               code_o, len_o, valid_o, err_o, busy_o);
    end
    key_i = 1'b0;
    repeat (2) @(negedge half_clk);
    rst = 1'b1;
    repeat (3) @(negedge half_clk);
    expect_char(4'b0000, 3'd1, 1'b0);
    drive(1, 1); drive(0, 3);
    wait_drain();
    n_checks++;
    if (n_valid - v0 != 1) begin
      n_fail++;
      $display("FAIL reset_strobes: got %0d strobes, required 1", n_valid - v0);
    end
  endtask

  task automatic test_saturation();
    expect_char(4'b0001, 3'd1, 1'b0);
    drive(1, 40);
    n_checks++;
    if (dut.cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL cnt_saturate: got cnt=%0d, required 15", dut.cnt);
    end
    drive(0, 3);
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sat_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    expect_char(4'b0000, 3'd1, 1'b0);
    expect_char(4'b0001, 3'd1, 1'b0);
    drive(1, 1); drive(0, 3); drive(1, 3); drive(0, 3);
    wait_drain();
    n_checks++;
    if (n_valid - v0 != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d strobes, required 2", n_valid - v0);
    end
  endtask

  initial begin
    key_i = 1'b0;
    rst = 1'b0;
    @(negedge half_clk);
    test_reset();
    test_letter_a();
    test_dash_threshold();
    test_gap_threshold();
    test_overflow();
    test_reset_mid_char();
    test_saturation();
    test_back_to_back();
    repeat (10) @(negedge half_clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/morse_rx.md
# morse_rx

Serial Morse receiver and decoder for the Morse FSM datapath. Samples a single key line on `half_clk` and measures mark and space durations. Classifies each mark as dot (0) or dash (1) and packs symbols LSB-first, the same order in which the transmit shift register emits them. On an inter-letter gap it presents the assembled code, the symbol count and an overflow flag with a one-cycle valid strobe.

## Interface

**Parameters**
- `DASH_TICKS`, default 3: a mark of at least this many high samples is a dash; fewer is a dot.
- `GAP_TICKS`, default 3: this many consecutive low samples after a mark end the character. Must be ≥ 2.
- `CNT_W`, default 4: width of the duration counter. The counter saturates at 2^CNT_W−1, which must be ≥ max(`DASH_TICKS`, `GAP_TICKS`).

**Ports**
- `half_clk`, input, 1: clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `key_i`, input, 1: raw key line, 1 = mark. Asynchronous to `half_clk`.
- `code_o`, output, 4: decoded symbols. Bit 0 is the first symbol; unused upper bits are 0.
- `len_o`, output, 3: number of symbols in `code_o`, range 0–4.
- `valid_o`, output, 1: one-cycle strobe; `code_o`, `len_o` and `err_o` are new on this cycle.
- `err_o`, output, 1: the character had more than 4 symbols. Valid with `valid_o` and held with the code.
- `busy_o`, output, 1: a character is being received (state ≠ IDLE).

## Operation

**Input synchronizer**
- `key_i` passes through a 2-flop synchronizer to produce `key_s`. All decisions use `key_s`.

**Internal registers**
- `cnt` [CNT_W]: saturating duration counter.
- `shreg` [4]: symbol accumulator.
- `len` [3]: symbol count.
- `ovf`: overflow flag.

**State machine**
- **IDLE**
  - `key_s`=1: go to MARK, `cnt`←1.
  - Otherwise stay in IDLE.
- **MARK**
  - `key_s`=1: `cnt`←`cnt`+1, saturating.
  - `key_s`=0: classify the mark as bit = (`cnt` ≥ `DASH_TICKS`).
    - If `len`<4: `shreg[len]`←bit and `len`←`len`+1.
    - Otherwise: `ovf`←1 and the symbol is dropped.
    - Then go to SPACE with `cnt`←1.
- **SPACE**
  - `key_s`=1: go to MARK, `cnt`←1. The same character continues.
  - `key_s`=0 and `cnt`+1 < `GAP_TICKS`: `cnt`←`cnt`+1.
  - `key_s`=0 and `cnt`+1 = `GAP_TICKS`: emit the character.
    - `code_o`←`shreg`, `len_o`←`len`, `err_o`←`ovf`, `valid_o`←1.
    - Clear `shreg`, `len` and `ovf`, then go to IDLE.

**Output behaviour**
- `code_o`, `len_o` and `err_o` hold their values until the next emit.
- `valid_o` is 0 in every cycle other than the emit cycle.
- `busy_o` is registered from the next-state value, so it is 1 in MARK and SPACE.

**Boundary rules**
- A mark of 1 sample is a valid dot. No glitch filtering is done beyond the synchronizer.
- A mark held longer than 2^CNT_W−1 samples saturates `cnt` and still classifies as a dash.
- A space of exactly `GAP_TICKS`−1 samples followed by a high sample continues the same character.
- No character is ever emitted with `len_o`=0, because IDLE only leaves on a mark.
- From the 5th symbol onward, `len` stays at 4, `shreg` keeps the first 4 symbols, and `ovf`=1.

**Reset**
- While `rst`=0, asynchronously: state = IDLE, and `cnt`, `shreg`, `len`, `ovf` and both synchronizer flops are 0.
- Outputs during reset: `code_o`=0, `len_o`=0, `valid_o`=0, `err_o`=0, `busy_o`=0.
- Reset in the middle of a character discards the partial character with no strobe.

## Timing

- **Synchronizer latency:** 2 `half_clk` edges from `key_i` to `key_s`.
- **Mark classification:** happens on the edge that samples the first low `key_s` after the mark.
- **Emit:** `valid_o` is registered high on the edge that samples the `GAP_TICKS`-th consecutive low `key_s`. It is high for exactly one cycle.
- **End-to-end latency:** last `key_i` falling edge to `valid_o` is 2 + `GAP_TICKS` edges.
- **Back-to-back characters:** a mark may start on the cycle immediately after the emit. IDLE accepts it on the next edge, and no character is lost.
- **Flow control:** none. The consumer must take the output within one character time; a new emit overwrites the outputs.

## Test plan

Defaults for all scenarios: `DASH_TICKS`=3, `GAP_TICKS`=3. Durations below are in `half_clk` cycles at `key_i`.

- **"A" (dot, dash):** key high 1, low 1, high 3, low 3 → one `valid_o` pulse with `code_o`=4'b0010, `len_o`=2, `err_o`=0, arriving 5 edges after the final fall.
- **Dash threshold:** high 2, low 3 → `code_o`=0, `len_o`=1. Then high 3, low 3 → `code_o`=4'b0001, `len_o`=1.
- **Gap threshold:** high 1, low 2, high 1, low 3 → a single strobe with `len_o`=2. The same sequence with the first low lengthened to 3 → two strobes, each with `len_o`=1.
- **Overflow:** five dots (high 1, low 1 each), then low 3 → `code_o`=0, `len_o`=4, `err_o`=1. A following "T" (high 3, low 3) → `code_o`=4'b0001, `len_o`=1, `err_o`=0.
- **Reset mid-character:** two dashes received, then `rst` pulsed low → all outputs 0 and `busy_o`=0. A following "E" (high 1, low 3) → `code_o`=0, `len_o`=1, `valid_o` pulses exactly once.
- **Saturation:** key high 40, low 3 → `cnt` holds at 15, then `code_o`=4'b0001, `len_o`=1, `err_o`=0.
